// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Computes D = A - B (mod 2^WIDTH) one bit per clock, LSB first, using a single
//   full-subtractor cell (half-subtractor plus borrow register).
//
//   Parameters:
//     WIDTH  operand/result width in bits (2..32)
//
//   Ports:
//     clk    clock, rising edge
//     rst    asynchronous active-high reset
//     start  request; sampled only while idle
//     A, B   minuend / subtrahend (unsigned), sampled with start
//     busy   high from the cycle after start through the done cycle
//     done   one-cycle pulse when D/Bo/Z are updated
//     D      difference A - B modulo 2^WIDTH
//     Bo     final borrow (A < B)
//     Z      D == 0
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             Z
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  res_q;
    logic              borrow_q;
    logic [CntW-1:0]   cnt_q;

    // Bit-serial cell: current LSBs of the operand shift registers plus carried borrow.
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             bout;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    always_comb begin
        a_bit    = a_q[0];
        b_bit    = b_q[0];
        d_bit    = a_bit ^ b_bit ^ borrow_q;
        bout     = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
        // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
        res_next = {d_bit, res_q[WIDTH-1:1]};
        last_bit = (cnt_q == CntW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            D        <= '0;
            Bo       <= 1'b0;
            Z        <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        res_q    <= '0;
                        borrow_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    res_q    <= res_next;
                    borrow_q <= bout;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // Publish only the completed result; D never shows partial values.
                        D       <= res_next;
                        Bo      <= bout;
                        Z       <= (res_next == '0);
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  request; sampled only while idle.
REQ-005 Port: A  input  WIDTH  minuend (unsigned); sampled with start.
REQ-006 Port: B  input  WIDTH  subtrahend (unsigned); sampled with start.
REQ-007 Port: busy  output  1  high while an operation is in progress, including the done cycle.
REQ-008 Port: done  output  1  one-cycle pulse; results are valid from this cycle onward.
REQ-009 Port: D  output  WIDTH  difference A-B, modulo 2^WIDTH.
REQ-010 Port: Bo  output  1  final borrow; 1 iff A < B (unsigned).
REQ-011 Port: Z  output  1  1 iff D == 0.

Function
REQ-012 The block SHALL compute A-B bit-serially, LSB first, one bit per clk cycle, using a half-subtractor cell plus a borrow register (full-subtractor behaviour).
REQ-013 Per-bit logic SHALL be d = a ^ b ^ bin and bout = (~a & b) | (~(a ^ b) & bin), with bin = 0 for bit 0.
REQ-014 The FSM SHALL have three states: IDLE, SHIFT and DONE; busy = (state != IDLE).
REQ-015 IDLE to SHIFT SHALL occur on the edge where start = 1.
  - Actions on that edge: load A and B into internal shift registers, clear the borrow register, clear the bit counter.
REQ-016 In SHIFT, each edge SHALL:
  - consume one bit of each operand;
  - shift the result bit into an internal result register;
  - update the borrow register;
  - increment the counter.
REQ-017 SHIFT to DONE SHALL occur on the edge that processes bit WIDTH-1.
  - On that same edge, the completed result SHALL be copied into D, Bo and Z.
REQ-018 DONE SHALL last exactly one cycle, with done = 1, then return to IDLE unconditionally.
REQ-019 Latency: if start is sampled at edge k, done SHALL be high between edges k+WIDTH and k+WIDTH+1.
REQ-020 start SHALL be ignored in SHIFT and DONE; no queuing, and A and B changes SHALL have no effect.
REQ-021 start asserted in the first IDLE cycle after DONE SHALL be accepted, giving a throughput of one result per WIDTH+2 cycles.
REQ-022 D, Bo and Z SHALL hold their last completed values until the next DONE transition; partial results SHALL never appear on D.
REQ-023 done SHALL be 0 in all states other than DONE.
REQ-024 Operands equal to 0 or all-ones SHALL need no special-case logic; the borrow chain SHALL handle all 2^(2*WIDTH) combinations.

Reset
REQ-025 rst = 1 SHALL immediately, without waiting for clk, force:
  - state = IDLE;
  - busy = 0, done = 0;
  - D = 0, Bo = 0;
  - Z = 1;
  - all internal registers = 0.
REQ-026 rst asserted mid-operation SHALL abort that operation.
  - No done pulse SHALL follow for it.
  - Outputs SHALL show reset values, not partial results.
REQ-027 After rst deasserts, the first rising edge with start = 1 SHALL be accepted normally.

Verification (WIDTH = 8)
REQ-028 Basic subtraction: A=0x5A, B=0x3C, start for 1 cycle -> done exactly 8 edges after the start edge; D=0x1E, Bo=0, Z=0.
REQ-029 Underflow: A=0x00, B=0x01 -> D=0xFF, Bo=1, Z=0.
  - A=0x3C, B=0x5A -> D=0xE2, Bo=1.
REQ-030 Equal operands: A=0xFF, B=0xFF -> D=0x00, Bo=0, Z=1.
  - A=0x00, B=0x00 -> D=0x00, Bo=0, Z=1.
REQ-031 Start while busy: start A=0x10, B=0x01; 3 cycles later pulse start with A=0xFF, B=0x00.
  - Required: one done only, D=0x0F.
  - start held high through DONE: the next operation begins the cycle after DONE.
REQ-032 Reset mid-operation: start A=0x80, B=0x01; assert rst asynchronously in the 4th SHIFT cycle.
  - Required: busy=0, D=0x00, Z=1 immediately, and no done.
  - Then start A=0x80, B=0x01 -> D=0x7F, Bo=0.
REQ-033 Exhaustive sweep: all 65536 A/B pairs back-to-back; D, Bo and Z checked against a reference model at every done, with done spacing of exactly 10 cycles.
